// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-slot TDM demultiplexer: serial sample input side and
// the parallel word / slot status outputs.
interface tdm_demux4_if #(
  parameter int WIDTH = 4
);
  logic             din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] ch0;
  logic [WIDTH-1:0] ch1;
  logic [WIDTH-1:0] ch2;
  logic [WIDTH-1:0] ch3;
  logic             out_valid;
  logic [1:0]       sel;
  logic [3:0]       sel_onehot;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  ch0, ch1, ch2, ch3, out_valid, sel, sel_onehot, locked, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output ch0, ch1, ch2, ch3, out_valid, sel, sel_onehot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Serial TDM stream to four parallel channel words; slots rotate 0..3 and each
// channel collects one bit per frame, MSB first.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          reset,
  tdm_demux4_if.slave  bus
);
  // state | meaning
  // HUNT  | waiting for a frame_sync-qualified sample to start slot 0
  // RUN   | aligned; sel tracks the slot expected for the next sample
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q [4];
  logic [WIDTH-1:0] sr_d [4];
  logic [WIDTH-1:0] ch_q [4];
  logic [WIDTH-1:0] ch_d [4];
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [3:0]       onehot_q, onehot_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ch_d        = ch_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    shifted     = {sr_q[sel_q][WIDTH-2:0], bus.din};
    first_bit   = {{(WIDTH-1){1'b0}}, bus.din};

    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            for (int k = 0; k < 4; k++) sr_d[k] = '0;
            sr_d[0] = first_bit;
            cnt_d   = '0;
            sel_d   = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if ((sel_q != 2'd0) && bus.frame_sync) begin
            // Early sync: realign on this sample as slot 0 of a fresh word.
            sync_err_d = 1'b1;
            for (int k = 0; k < 4; k++) sr_d[k] = '0;
            sr_d[0] = first_bit;
            cnt_d   = '0;
            sel_d   = 2'd1;
          end else if ((sel_q == 2'd0) && !bus.frame_sync) begin
            sync_err_d = 1'b1;
            for (int k = 0; k < 4; k++) sr_d[k] = '0;
            cnt_d   = '0;
            sel_d   = 2'd0;
            state_d = HUNT;
          end else begin
            sr_d[sel_q] = shifted;
            sel_d       = sel_q + 2'd1;
            if (sel_q == 2'd3) begin
              if (cnt_q == CW'(WIDTH - 1)) begin
                ch_d[0]     = sr_q[0];
                ch_d[1]     = sr_q[1];
                ch_d[2]     = sr_q[2];
                ch_d[3]     = shifted;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                for (int k = 0; k < 4; k++) sr_d[k] = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    onehot_d = (state_d == RUN) ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      sel_q       <= 2'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      onehot_q    <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        sr_q[k] <= '0;
        ch_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      onehot_q    <= onehot_d;
      for (int k = 0; k < 4; k++) begin
        sr_q[k] <= sr_d[k];
        ch_q[k] <= ch_d[k];
      end
    end
  end

  assign bus.ch0        = ch_q[0];
  assign bus.ch1        = ch_q[1];
  assign bus.ch2        = ch_q[2];
  assign bus.ch3        = ch_q[3];
  assign bus.out_valid  = out_valid_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.sel        = sel_q;
  assign bus.sel_onehot = onehot_q;
  assign bus.locked     = (state_q == RUN);
endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: expected channel words are queued as
// each stream is driven and popped when out_valid fires.
module tb_tdm_demux4;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tdm_demux4_if #(.WIDTH(WIDTH)) bus ();
  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ov_cnt   = 0;
  int se_cnt   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;
  logic [15:0] mon_got;

  // Sample i of a stream is s[15-i]; frame j, slot k is sample 4*j+k.
  localparam logic [15:0] STREAM_A = 16'b1010_0110_1110_0011;
  localparam logic [15:0] STREAM_B = 16'b0111_1001_0100_1101;
  localparam logic [15:0] STREAM_C = 16'b1100_0011_1011_0110;

  function automatic logic [15:0] words_of(input logic [15:0] s);
    logic [3:0] w [4];
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        w[k][3-j] = s[15-(4*j+k)];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [15:0] ch_now();
    return {bus.ch0, bus.ch1, bus.ch2, bus.ch3};
  endfunction

  task automatic sample(input logic b, input logic fs, input int gap);
    bus.din        = b;
    bus.frame_sync = fs;
    bus.din_valid  = 1'b1;
    @(posedge clk); #1;
    bus.din_valid  = 1'b0;
    repeat (gap) begin
      bus.din        = 1'($urandom_range(0, 1));
      bus.frame_sync = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard side: every out_valid pulse must match the oldest queued word set.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.out_valid === 1'b1) begin
        ov_cnt++;
        n_checks++;
        mon_got = ch_now();
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_unexpected: out_valid with nothing queued, ch=%h", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL scoreboard_words: got ch0..3=%h required %h", mon_got, mon_exp);
          end
        end
      end
      if (bus.sync_err === 1'b1) se_cnt++;
      if (bus.out_valid === 1'b1 || bus.sync_err === 1'b1) begin
        n_checks++;
        if (bus.out_valid === 1'b1 && bus.sync_err === 1'b1) begin
          n_fail++;
          $display("FAIL ov_se_exclusive: out_valid=1 sync_err=1 required not both");
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.din_valid  = 1'(c == 0);
      bus.din        = 1'(c);
      bus.frame_sync = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (ch_now() !== 16'h0000) begin n_fail++; $display("FAIL reset_ch: got %h required 0000", ch_now()); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b required 0", bus.locked); end
    n_checks++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d required 0", bus.sel); end
    n_checks++; if (bus.sel_onehot !== 4'b0000) begin n_fail++; $display("FAIL reset_onehot: got %b required 0000", bus.sel_onehot); end
    n_checks++; if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b required 0", bus.sync_err); end
    bus.din_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_normal();
    logic [15:0] s;
    int ov0;
    s = STREAM_A;
    ov0 = ov_cnt;
    exp_q.push_back(words_of(s));
    for (int i = 0; i < 16; i++) begin
      sample(s[15-i], 1'(i % 4 == 0), 0);
      n_checks++;
      if (bus.sel !== 2'((i + 1) % 4)) begin
        n_fail++; $display("FAIL normal_sel[%0d]: got %0d required %0d", i, bus.sel, (i + 1) % 4);
      end
      n_checks++;
      if (bus.sel_onehot !== 4'(1 << ((i + 1) % 4))) begin
        n_fail++; $display("FAIL normal_onehot[%0d]: got %b required %b", i, bus.sel_onehot, 4'(1 << ((i + 1) % 4)));
      end
      n_checks++;
      if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL normal_locked[%0d]: got %b required 1", i, bus.locked); end
      n_checks++;
      if (bus.out_valid !== 1'(i == 15)) begin
        n_fail++; $display("FAIL normal_out_valid[%0d]: got %b required %b", i, bus.out_valid, 1'(i == 15));
      end
    end
    idle(1);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL normal_pulse_width: got %b required 0", bus.out_valid); end
    n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL normal_pulse_count: got %0d required 1", ov_cnt - ov0); end
    n_checks++; if (ch_now() !== 16'b1010_0110_1111_0001) begin n_fail++; $display("FAIL normal_words: got %b required 1010011011110001", ch_now()); end
  endtask

  task automatic test_gapped();
    logic [15:0] s;
    int ov0;
    s = STREAM_B;
    ov0 = ov_cnt;
    exp_q.push_back(words_of(s));
    for (int i = 0; i < 16; i++)
      sample(s[15-i], 1'(i % 4 == 0), $urandom_range(1, 3));
    idle(2);
    n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL gapped_pulse_count: got %0d required 1", ov_cnt - ov0); end
    n_checks++; if (ch_now() !== words_of(s)) begin n_fail++; $display("FAIL gapped_words: got %h required %h", ch_now(), words_of(s)); end
  endtask

  task automatic test_early_sync();
    logic [15:0] a;
    logic [15:0] c;
    int ov0, se0;
    a = STREAM_A;
    c = STREAM_C;
    ov0 = ov_cnt;
    se0 = se_cnt;
    for (int i = 0; i < 6; i++) sample(a[15-i], 1'(i % 4 == 0), 0);
    n_checks++; if (se_cnt !== se0) begin n_fail++; $display("FAIL early_no_err_before: got %0d pulses required 0", se_cnt - se0); end
    exp_q.push_back(words_of(c));
    sample(c[15], 1'b1, 0);
    n_checks++; if (bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL early_sync_err: got %b required 1", bus.sync_err); end
    n_checks++; if (bus.sel !== 2'd1) begin n_fail++; $display("FAIL early_sel: got %0d required 1", bus.sel); end
    n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL early_locked: got %b required 1", bus.locked); end
    for (int i = 1; i < 16; i++) begin
      sample(c[15-i], 1'(i % 4 == 0), 0);
      if (i == 1) begin
        n_checks++; if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL early_err_width: got %b required 0", bus.sync_err); end
      end
    end
    idle(2);
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("FAIL early_err_count: got %0d required 1", se_cnt - se0); end
    n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL early_pulse_count: got %0d required 1", ov_cnt - ov0); end
    n_checks++; if (ch_now() !== words_of(c)) begin n_fail++; $display("FAIL early_words: got %h required %h", ch_now(), words_of(c)); end
  endtask

  task automatic test_missing_sync();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] held;
    int ov0, se0;
    a = STREAM_A;
    b = STREAM_B;
    held = words_of(STREAM_C);
    ov0 = ov_cnt;
    se0 = se_cnt;
    for (int i = 0; i < 4; i++) sample(a[15-i], 1'(i == 0), 0);
    sample(1'b1, 1'b0, 0);
    n_checks++; if (bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL missing_sync_err: got %b required 1", bus.sync_err); end
    n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL missing_locked: got %b required 0", bus.locked); end
    n_checks++; if (bus.sel_onehot !== 4'b0000) begin n_fail++; $display("FAIL missing_onehot: got %b required 0000", bus.sel_onehot); end
    n_checks++; if (ch_now() !== held) begin n_fail++; $display("FAIL missing_hold: got %h required %h", ch_now(), held); end
    for (int i = 0; i < 3; i++) sample(1'(i), 1'b0, 0);
    n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL missing_stays_hunt: got %b required 0", bus.locked); end
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("FAIL missing_err_count: got %0d required 1", se_cnt - se0); end
    exp_q.push_back(words_of(b));
    for (int i = 0; i < 16; i++) sample(b[15-i], 1'(i % 4 == 0), 0);
    idle(2);
    n_checks++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL missing_relock: got %b required 1", bus.locked); end
    n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL missing_pulse_count: got %0d required 1", ov_cnt - ov0); end
    n_checks++; if (ch_now() !== words_of(b)) begin n_fail++; $display("FAIL missing_words: got %h required %h", ch_now(), words_of(b)); end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] a;
    logic [15:0] c;
    int ov0;
    a = STREAM_A;
    c = STREAM_C;
    for (int i = 0; i < 10; i++) sample(a[15-i], 1'(i % 4 == 0), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (ch_now() !== 16'h0000) begin n_fail++; $display("FAIL midreset_ch: got %h required 0000", ch_now()); end
    n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL midreset_locked: got %b required 0", bus.locked); end
    ov0 = ov_cnt;
    exp_q.push_back(words_of(c));
    for (int i = 0; i < 15; i++) sample(c[15-i], 1'(i % 4 == 0), 0);
    n_checks++; if (ov_cnt !== ov0) begin n_fail++; $display("FAIL midreset_early_pulse: got %0d pulses required 0", ov_cnt - ov0); end
    sample(c[0], 1'b0, 0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_out_valid: got %b required 1", bus.out_valid); end
    idle(2);
    n_checks++; if (ch_now() !== words_of(c)) begin n_fail++; $display("FAIL midreset_words: got %h required %h", ch_now(), words_of(c)); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    #1;
    test_reset();
    test_normal();
    test_gapped();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_word();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
Receive-side counterpart of the team's 4:1 selector/mux datapath. Takes one serial time-division-multiplexed bit stream, in which slots 0..3 rotate under a 2-bit selector, and steers each slot back to its own channel. Each channel accumulates WIDTH bits, one per frame, and all four words are presented in parallel with a one-cycle valid strobe. The current slot is also exposed as a 2-bit code and as a one-hot decode, for lane enables and debug.

Parameters:
WIDTH, 4, bits per channel word (one bit per frame; valid range 2..16)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
din  input  1  serial TDM data bit
din_valid  input  1  din is a sample this cycle; no state advances when low
frame_sync  input  1  qualified by din_valid; marks the slot-0 sample of a frame
ch0  output  WIDTH  last completed word for slot 0
ch1  output  WIDTH  last completed word for slot 1
ch2  output  WIDTH  last completed word for slot 2
ch3  output  WIDTH  last completed word for slot 3
out_valid  output  1  one-cycle pulse when ch0..ch3 update
sel  output  2  slot index expected for the next sample
sel_onehot  output  4  decode of sel; bit k high when sel==k; 0000 in HUNT
locked  output  1  high in RUN state
sync_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (reset high at a clk edge, overriding everything else):
  - state=HUNT; sel=0, bit counter=0.
  - ch0..ch3, the shift registers, out_valid, sync_err and locked are all 0.
  - Reset asserted mid-word discards all partial data.
- State machine, HUNT / RUN:
  - Evaluated only on cycles with din_valid=1; with din_valid=0 all state holds and out_valid and sync_err are 0.
  - HUNT, frame_sync=1: capture din as slot 0, frame 0; go to RUN; sel=1.
  - HUNT, frame_sync=0: sample dropped; stay in HUNT; no sync_err.
  - RUN, sel!=0, frame_sync=0: normal sample; capture into channel sel; sel increments.
  - RUN, sel!=0, frame_sync=1 (early sync): sync_err pulses next cycle. Partial shift registers and bit counter are cleared. The sample is taken as slot 0, frame 0, and sel=1.
  - RUN, sel==0, frame_sync=1: normal start of frame.
  - RUN, sel==0, frame_sync=0 (missing sync): sync_err pulses next cycle. Go to HUNT and clear partial data; the sample is dropped.
- Capture rule:
  - Shift register of channel k <= {sr_k[WIDTH-2:0], din}, so the first frame's bit ends up in the MSB.
  - sel wraps 3->0 after slot 3.
  - The bit counter increments after each slot-3 sample.
- Word completion:
  - Triggered by the slot-3 sample when the bit counter == WIDTH-1.
  - On that same clk edge, ch0..ch3 load the full words; ch3 includes the current din.
  - out_valid is high for exactly the following cycle.
  - The bit counter returns to 0 and the shift registers restart empty. The state stays RUN.
- Output holding: ch0..ch3 hold their value until the next completion. Sync errors and HUNT do not clear them; only reset does.
- Outputs are registered: locked, sel and sel_onehot reflect state after the edge. out_valid and sync_err are never high in the same cycle.
- Back-to-back: din_valid may be high every cycle (full rate), or gapped arbitrarily; results must be identical.

Test Plan:
- Reset: hold reset 2 cycles with din/din_valid toggling -> ch0..ch3=0, out_valid=0, locked=0, sel=0, sel_onehot=0000.
- Normal word, WIDTH=4, full rate, frame_sync on every slot 0:
  - Frames in slot order: f0=1,0,1,0; f1=0,1,1,0; f2=1,1,1,0; f3=0,0,1,1.
  - Expect one out_valid pulse the cycle after the 16th sample, with ch0=1010, ch1=0110, ch2=1111, ch3=0001.
  - sel_onehot walks 0010,0100,1000,0001 after lock.
- Gapped input: same stream with din_valid low for 1-3 random cycles between samples -> identical words; out_valid pulses exactly once.
- Early sync: after 6 good samples, assert frame_sync on the slot-2 sample -> sync_err pulses once; sel=1. A following clean 16-sample stream yields the correct words, with no stale bits.
- Missing sync: frame_sync=0 on a slot-0 sample -> sync_err pulse, locked=0, prior ch0..ch3 retained. Samples are dropped until the next frame_sync, then relock.
- Reset mid-word: reset after 10 samples, then a clean 16-sample stream -> first out_valid only after the 16th post-reset sample, with correct words.
